// File: rtl/window_fetch_if.sv
// rtl/window_fetch_if.sv - handshake bundle between window_fetch and its address counter, memory and consumer
interface window_fetch_if #(
    parameter int PIX_W = 8
);
    logic                 i_start;
    logic [15:0]          i_img_width;
    logic [15:0]          i_img_height;
    logic                 o_inc_raddr;
    logic                 i_r_ready;
    logic [31:0]          i_raddr;
    logic                 o_mem_read;
    logic [31:0]          o_mem_addr;
    logic                 i_mem_wait;
    logic [PIX_W-1:0]     i_mem_rdata;
    logic                 i_mem_rdata_valid;
    logic [9*PIX_W-1:0]   o_window;
    logic                 o_window_valid;
    logic                 i_window_ack;
    logic                 o_busy;
    logic                 o_frame_done;

    modport master (
        input  i_start, i_img_width, i_img_height,
        output o_inc_raddr,
        input  i_r_ready, i_raddr,
        output o_mem_read, o_mem_addr,
        input  i_mem_wait, i_mem_rdata, i_mem_rdata_valid,
        output o_window, o_window_valid,
        input  i_window_ack,
        output o_busy, o_frame_done
    );

    modport slave (
        output i_start, i_img_width, i_img_height,
        input  o_inc_raddr,
        output i_r_ready, i_raddr,
        input  o_mem_read, o_mem_addr,
        output i_mem_wait, i_mem_rdata, i_mem_rdata_valid,
        input  o_window, o_window_valid,
        output i_window_ack,
        input  o_busy, o_frame_done
    );
endinterface

// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - fetches nine single-beat pixel reads per 3x3 window and hands each window to the consumer
module window_fetch #(
    parameter int PIX_W = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    window_fetch_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ADDR,
        S_WAIT_ADDR,
        S_ISSUE,
        S_WAIT_DATA,
        S_WINDOW_OUT,
        S_DONE
    } state_t;

    state_t           state;
    logic [3:0]       pix_cnt;
    logic [31:0]      win_cnt;
    logic [31:0]      total;
    logic [PIX_W-1:0] win_q [9];

    logic [31:0] total_in;
    logic        too_small;

    // Only meaningful when both dimensions are >= 3; the small case forces total to zero.
    assign total_in  = {16'd0, bus.i_img_width - 16'd2} * {16'd0, bus.i_img_height - 16'd2};
    assign too_small = (bus.i_img_width < 16'd3) || (bus.i_img_height < 16'd3);

    for (genvar k = 0; k < 9; k++) begin : g_win
        assign bus.o_window[k*PIX_W +: PIX_W] = win_q[k];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= S_IDLE;
            pix_cnt            <= '0;
            win_cnt            <= '0;
            total              <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
            bus.o_inc_raddr    <= 1'b0;
            bus.o_mem_read     <= 1'b0;
            bus.o_mem_addr     <= '0;
            bus.o_window_valid <= 1'b0;
            bus.o_busy         <= 1'b0;
            bus.o_frame_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        pix_cnt    <= '0;
                        win_cnt    <= '0;
                        bus.o_busy <= 1'b1;
                        if (too_small) begin
                            total            <= '0;
                            bus.o_frame_done <= 1'b1;
                            state            <= S_DONE;
                        end else begin
                            total           <= total_in;
                            bus.o_inc_raddr <= 1'b1;
                            state           <= S_REQ_ADDR;
                        end
                    end
                end

                S_REQ_ADDR: begin
                    bus.o_inc_raddr <= 1'b0;
                    state           <= S_WAIT_ADDR;
                end

                S_WAIT_ADDR: begin
                    if (bus.i_r_ready) begin
                        bus.o_mem_addr <= bus.i_raddr;
                        bus.o_mem_read <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (!bus.i_mem_wait) begin
                        bus.o_mem_read <= 1'b0;
                        state          <= S_WAIT_DATA;
                    end
                end

                S_WAIT_DATA: begin
                    if (bus.i_mem_rdata_valid) begin
                        win_q[pix_cnt] <= bus.i_mem_rdata;
                        if (pix_cnt == 4'd8) begin
                            bus.o_window_valid <= 1'b1;
                            state              <= S_WINDOW_OUT;
                        end else begin
                            pix_cnt         <= pix_cnt + 4'd1;
                            bus.o_inc_raddr <= 1'b1;
                            state           <= S_REQ_ADDR;
                        end
                    end
                end

                S_WINDOW_OUT: begin
                    if (bus.i_window_ack) begin
                        bus.o_window_valid <= 1'b0;
                        win_cnt            <= win_cnt + 32'd1;
                        pix_cnt            <= '0;
                        if (win_cnt + 32'd1 == total) begin
                            bus.o_frame_done <= 1'b1;
                            state            <= S_DONE;
                        end else begin
                            bus.o_inc_raddr <= 1'b1;
                            state           <= S_REQ_ADDR;
                        end
                    end
                end

                S_DONE: begin
                    bus.o_frame_done <= 1'b0;
                    bus.o_busy       <= 1'b0;
                    state            <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_fetch.sv
// tb/tb_window_fetch.sv - randomized scoreboard bench for window_fetch
module tb_window_fetch;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    window_fetch_if #(.PIX_W(8)) bus ();
    window_fetch #(.PIX_W(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // environment configuration
    int cfg_lat_min = 1, cfg_lat_max = 1;
    int cfg_stall_min = 0, cfg_stall_max = 0;
    int cfg_ack_min = 2, cfg_ack_max = 2;
    bit cfg_spur = 1'b0;
    logic [7:0] cfg_salt = 8'h00;

    // environment state
    int addr_cnt = 0, mem_cnt = 0, stall_left = 0, ack_left = 0;
    bit in_req = 1'b0, ack_armed = 1'b0, ack_last = 1'b0;
    logic [7:0]  mem_data = '0;
    logic [31:0] last_raddr = '0;
    int n_addr = 0, inc_cnt = 0, memrd_cnt = 0, win_seen = 0;

    logic [71:0] exp_q [$];
    logic [71:0] cur_exp = '0;
    bit prev_valid = 1'b0, prev_done = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // address counter, memory and consumer models
    initial begin
        forever begin
            @(negedge clk);
            bus.i_r_ready = 1'b0;
            bus.i_mem_rdata_valid = 1'b0;
            bus.i_window_ack = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.i_mem_rdata_valid = 1'b1;
                    bus.i_mem_rdata = mem_data;
                end
            end
            if (!n_rst) begin
                addr_cnt = 0; in_req = 1'b0; ack_armed = 1'b0; ack_last = 1'b0;
                bus.i_mem_wait = 1'b0;
            end else begin
                if (ack_last) chk("valid_drop", 72'(bus.o_window_valid), 72'd0);
                ack_last = 1'b0;
                if (addr_cnt > 0) begin
                    addr_cnt--;
                    if (addr_cnt == 0) begin
                        bus.i_r_ready = 1'b1;
                        last_raddr = 32'h100 + 32'(n_addr);
                        bus.i_raddr = last_raddr;
                        n_addr++;
                    end
                end
                if (bus.o_inc_raddr) begin
                    addr_cnt = $urandom_range(3, 1);
                    inc_cnt++;
                end
                if (in_req) chk("mem_read_hold", 72'(bus.o_mem_read), 72'd1);
                if (bus.o_mem_read) begin
                    chk("mem_addr", 72'(bus.o_mem_addr), 72'(last_raddr));
                    if (!in_req) begin
                        in_req = 1'b1;
                        stall_left = $urandom_range(cfg_stall_max, cfg_stall_min);
                    end
                    if (stall_left > 0) begin
                        bus.i_mem_wait = 1'b1;
                        stall_left--;
                    end else begin
                        bus.i_mem_wait = 1'b0;
                        in_req = 1'b0;
                        mem_cnt = $urandom_range(cfg_lat_max, cfg_lat_min);
                        mem_data = bus.o_mem_addr[7:0] ^ cfg_salt;
                        memrd_cnt++;
                    end
                end else begin
                    bus.i_mem_wait = cfg_spur ? 1'($urandom_range(1, 0)) : 1'b0;
                end
                if (bus.o_window_valid) begin
                    if (!ack_armed) begin
                        ack_armed = 1'b1;
                        ack_left = $urandom_range(cfg_ack_max, cfg_ack_min);
                    end
                    if (ack_left == 0) begin
                        bus.i_window_ack = 1'b1;
                        ack_last = 1'b1;
                    end else begin
                        ack_left--;
                    end
                end else begin
                    ack_armed = 1'b0;
                end
                // Stray handshakes while the engine cannot legally accept them.
                if (cfg_spur && (!bus.o_busy || bus.o_window_valid) && !bus.i_r_ready
                    && !bus.i_mem_rdata_valid && $urandom_range(2, 0) == 0) begin
                    bus.i_r_ready = 1'b1;
                    bus.i_raddr = $urandom;
                    bus.i_mem_rdata_valid = 1'b1;
                    bus.i_mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_valid = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.o_window_valid && !prev_valid) begin
                    win_seen++;
                    if (exp_q.size() == 0) begin
                        chk("win_extra", bus.o_window, 72'd0);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        chk("window", bus.o_window, cur_exp);
                    end
                end else if (bus.o_window_valid) begin
                    chk("win_hold", bus.o_window, cur_exp);
                    chk("no_inc_hold", 72'(bus.o_inc_raddr), 72'd0);
                end
                if (prev_done) begin
                    chk("busy_fall", 72'(bus.o_busy), 72'd0);
                    chk("done_pulse", 72'(bus.o_frame_done), 72'd0);
                end
                prev_valid = bus.o_window_valid;
                prev_done = bus.o_frame_done;
            end
        end
    end

    task automatic run_frame(input int w, input int h, input bit mid_start);
        int total;
        int cyc;
        logic [31:0] a;
        logic [71:0] win;
        total = (w < 3 || h < 3) ? 0 : (w - 2) * (h - 2);
        for (int wi = 0; wi < total; wi++) begin
            for (int k = 0; k < 9; k++) begin
                a = 32'h100 + 32'(9 * wi + k);
                win[k*8 +: 8] = a[7:0] ^ cfg_salt;
            end
            exp_q.push_back(win);
        end
        n_addr = 0; inc_cnt = 0; memrd_cnt = 0; win_seen = 0;
        bus.i_img_width = 16'(w);
        bus.i_img_height = 16'(h);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_img_width = 16'($urandom);
        bus.i_img_height = 16'($urandom);
        chk("busy_rise", 72'(bus.o_busy), 72'd1);
        if (total == 0) chk("done_early", 72'(bus.o_frame_done), 72'd1);
        else chk("inc_first", 72'(bus.o_inc_raddr), 72'd1);
        cyc = 0;
        while (!bus.o_frame_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0;
            if (mid_start && cyc == 20) begin
                bus.i_img_width = 16'd7;
                bus.i_img_height = 16'd7;
                bus.i_start = 1'b1;
            end
        end
        bus.i_start = 1'b0;
        chk("frame_timeout", 72'(bus.o_frame_done), 72'd1);
        chk("inc_count", 72'(inc_cnt), 72'(9 * total));
        chk("memrd_count", 72'(memrd_cnt), 72'(9 * total));
        chk("win_count", 72'(win_seen), 72'(total));
        chk("win_left", 72'(exp_q.size()), 72'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inc"}, 72'(bus.o_inc_raddr), 72'd0);
        chk({tag, "_mrd"}, 72'(bus.o_mem_read), 72'd0);
        chk({tag, "_maddr"}, 72'(bus.o_mem_addr), 72'd0);
        chk({tag, "_win"}, bus.o_window, 72'd0);
        chk({tag, "_wvld"}, 72'(bus.o_window_valid), 72'd0);
        chk({tag, "_busy"}, 72'(bus.o_busy), 72'd0);
        chk({tag, "_done"}, 72'(bus.o_frame_done), 72'd0);
    endtask

    initial begin
        int cyc;
        bus.i_start = 1'b0; bus.i_img_width = '0; bus.i_img_height = '0;
        bus.i_r_ready = 1'b0; bus.i_raddr = '0; bus.i_mem_wait = 1'b0;
        bus.i_mem_rdata = '0; bus.i_mem_rdata_valid = 1'b0; bus.i_window_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(5, 5, 1'b0);

        cfg_stall_min = 3; cfg_stall_max = 3;
        run_frame(3, 3, 1'b0);
        cfg_stall_min = 0; cfg_stall_max = 0;

        run_frame(2, 100, 1'b0);
        run_frame(100, 1, 1'b0);

        cfg_ack_min = 10; cfg_ack_max = 10;
        run_frame(4, 4, 1'b0);
        cfg_ack_min = 0; cfg_ack_max = 0;
        run_frame(4, 4, 1'b0);

        cfg_spur = 1'b1;
        cfg_lat_min = 1; cfg_lat_max = 4;
        cfg_stall_min = 0; cfg_stall_max = 2;
        cfg_ack_min = 0; cfg_ack_max = 4;
        run_frame(4, 5, 1'b1);
        for (int f = 0; f < 4; f++) begin
            cfg_salt = 8'($urandom);
            run_frame($urandom_range(6, 2), $urandom_range(6, 2), 1'($urandom_range(1, 0)));
        end
        cfg_spur = 1'b0;
        cfg_salt = 8'h00;

        // reset while the fifth pixel read is outstanding
        cfg_lat_min = 3; cfg_lat_max = 3;
        cfg_stall_min = 0; cfg_stall_max = 0;
        n_addr = 0; memrd_cnt = 0;
        bus.i_img_width = 16'd5; bus.i_img_height = 16'd5;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cyc = 0;
        while (memrd_cnt < 5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_pix4", 72'(memrd_cnt), 72'd5);
        #2 n_rst = 1'b0;
        #1 chk_reset_outputs("async");
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_outputs("post");
        cfg_lat_min = 1; cfg_lat_max = 2;
        run_frame(3, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/window_fetch.md
# window_fetch

Read-side fetch engine for the 3x3 edge-detection datapath. Requests read addresses from the address counter one at a time, issues one single-beat pixel read per address to image memory, and packs nine returned pixels into a 3x3 window for the Sobel/gradient stage. Sits between the address counter, the memory read port and the window consumer. It walks the frame once per start command.

## Interface
- PIX_W, 8, pixel width in bits.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a frame fetch. Ignored unless in IDLE.
- i_img_width  in  16  image width in pixels; sampled on accepted start.
- i_img_height  in  16  image height in pixels; sampled on accepted start.
- o_inc_raddr  out  1  one-cycle pulse to the address counter requesting the next read address.
- i_r_ready  in  1  address counter pulse: i_raddr is valid this cycle.
- i_raddr  in  32  read address from the address counter.
- o_mem_read  out  1  memory read request; held until accepted.
- o_mem_addr  out  32  memory read address; stable while o_mem_read is high.
- i_mem_wait  in  1  memory stall; request is accepted in a cycle with o_mem_read=1 and i_mem_wait=0.
- i_mem_rdata  in  PIX_W  returned pixel.
- i_mem_rdata_valid  in  1  i_mem_rdata valid this cycle.
- o_window  out  9*PIX_W  window; pixel k at bits [PIX_W*k+PIX_W-1 : PIX_W*k], k = fetch order 0..8.
- o_window_valid  out  1  o_window complete; held until i_window_ack.
- i_window_ack  in  1  consumer has taken the window.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse after the last window is acknowledged.

## Operation
- States: IDLE, REQ_ADDR, WAIT_ADDR, ISSUE, WAIT_DATA, WINDOW_OUT, DONE.
- IDLE: on i_start, latch width and height. Compute total = (width-2)*(height-2) as a 32-bit unsigned value. Clear pix_cnt (4 bits) and win_cnt (32 bits).
  - If width<3 or height<3, total=0: go to DONE with no address or memory activity.
  - Otherwise go to REQ_ADDR.
- REQ_ADDR: assert o_inc_raddr for exactly one cycle, then go to WAIT_ADDR.
- WAIT_ADDR: wait for i_r_ready. On it, register i_raddr into o_mem_addr and go to ISSUE. Any i_r_ready seen outside WAIT_ADDR is ignored.
- ISSUE: o_mem_read=1. Go to WAIT_DATA in the cycle where i_mem_wait=0.
- WAIT_DATA: on i_mem_rdata_valid, write i_mem_rdata into window slot pix_cnt.
  - If pix_cnt==8: go to WINDOW_OUT.
  - Else: pix_cnt+1, go to REQ_ADDR.
  - i_mem_rdata_valid is ignored in every other state.
- WINDOW_OUT: o_window_valid=1. o_window is frozen. On i_window_ack:
  - win_cnt+1 and pix_cnt=0.
  - If win_cnt+1 == total: go to DONE.
  - Else: go to REQ_ADDR.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- Exactly one o_inc_raddr per pixel, so 9*total pulses per frame.

## Timing
- All outputs are registered. Reset values: o_inc_raddr=0, o_mem_read=0, o_mem_addr=0, o_window=0, o_window_valid=0, o_busy=0, o_frame_done=0. State=IDLE, counters=0.
- Start accepted at edge T: o_busy=1 and o_inc_raddr=1 in cycle T+1.
- i_r_ready in cycle A: o_mem_read=1 with o_mem_addr=i_raddr in cycle A+1.
- Accept in cycle M: WAIT_DATA from M+1. Memory latency is arbitrary (≥1 cycle).
- rdata_valid in cycle D:
  - Next o_inc_raddr in D+1.
  - Or, for the 9th pixel, o_window_valid=1 in D+1.
- Ack in cycle K (window_valid high):
  - o_window_valid=0 in K+1.
  - Next o_inc_raddr in K+1, or o_frame_done in K+1.
- Ack arriving in the same cycle valid rises counts. Ack while valid is low is ignored.
- Minimum per pixel: 1 (REQ) + address-counter latency + 1 (ISSUE, no stall) + memory latency.
- Reset mid-frame: all outputs return to reset values asynchronously. A partially filled window is discarded. Late memory data after reset is ignored.
- i_start while busy: no effect, and width/height are not re-sampled.

## Test plan
- Width=5, height=5, address model returns 0x100+n, memory returns data=addr[7:0], 1-cycle latency, ack 2 cycles after valid -> 9 windows, 81 inc pulses. Window 0 = bytes 0x00..0x08 in slots 0..8. One o_frame_done pulse; o_busy falls the cycle after.
- Width=3, height=3, i_mem_wait held 3 cycles on each request -> o_mem_addr/o_mem_read stable through the stall. Exactly one window, then o_frame_done.
- Width=2, height=100 -> o_frame_done the cycle after start. No o_inc_raddr, no o_mem_read.
- Width=4, height=4, ack withheld 10 cycles -> o_window_valid and o_window stay constant and no new o_inc_raddr during the wait. Ack in the cycle valid first rises -> valid low next cycle.
- Spurious i_r_ready and i_mem_rdata_valid pulses injected in IDLE and in WINDOW_OUT -> no state change and no window corruption. Second i_start mid-frame ignored.
- n_rst asserted during WAIT_DATA of pixel 4 -> all outputs reset immediately. Fresh start with width=3, height=3 -> clean window from slot 0.
